// File: rtl/cpu_mul_pkg.sv
// Shared op encoding, signedness helpers and stage payload for cpu_mul_pipe.
package cpu_mul_pkg;

  localparam logic [1:0] MUL    = 2'd0;
  localparam logic [1:0] MULXSS = 2'd1;
  localparam logic [1:0] MULXSU = 2'd2;
  localparam logic [1:0] MULXUU = 2'd3;

  // Payload tag field is sized for the widest supported tag; top truncates.
  localparam int MAX_TAG_W = 16;

  typedef struct packed {
    logic [1:0]           op;
    logic [MAX_TAG_W-1:0] tag;
    logic                 valid;
  } mul_pay_t;

  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == MULXSS) || (op == MULXSU);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return (op == MULXSS);
  endfunction

  function automatic logic op_is_high(input logic [1:0] op);
    return (op != MUL);
  endfunction

endpackage

// File: rtl/cpu_mul_pp.sv
// One HALF_W x HALF_W partial-product multiplier with per-operand signedness.
module cpu_mul_pp #(
  parameter int HALF_W = 16
) (
  input  logic [HALF_W-1:0]        a,
  input  logic [HALF_W-1:0]        b,
  input  logic                     signa,
  input  logic                     signb,
  output logic signed [2*HALF_W+1:0] p
);
  localparam int P_W = 2*HALF_W+2;

  logic signed [HALF_W:0] ax, bx;

  // One extra bit lets a single signed multiply cover both signed and unsigned halves.
  assign ax = {signa & a[HALF_W-1], a};
  assign bx = {signb & b[HALF_W-1], b};
  assign p  = P_W'(ax) * P_W'(bx);

endmodule

// File: rtl/cpu_mul_pipe.sv
// Pipelined DATA_W x DATA_W multiplier, valid/ready with flush.
// Define CPU_MUL_OUT_REG_EN to add an output register stage (latency 3 instead of 2).
module cpu_mul_pipe
  import cpu_mul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [2*DATA_W-1:0] out_prod,
  output logic [TAG_W-1:0]    out_tag
);
  localparam int HALF_W = DATA_W/2;
  localparam int PP_W   = DATA_W+2;
  localparam int SUM_W  = 2*DATA_W+2;
  localparam int PROD_W = 2*DATA_W;
`ifdef CPU_MUL_OUT_REG_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  logic                   advance;
  logic                   sa, sb;
  mul_pay_t               pay_in;
  mul_pay_t               pay_q  [STAGES:1];
  logic signed [PP_W-1:0] pp_d   [4];
  logic signed [PP_W-1:0] pp_q   [4];
  logic [PROD_W-1:0]      prod_q [STAGES:2];
  logic signed [SUM_W-1:0] sum_full;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign sa       = op_a_signed(in_op);
  assign sb       = op_b_signed(in_op);

  always_comb begin
    pay_in       = '0;
    pay_in.op    = in_op;
    pay_in.tag   = MAX_TAG_W'(in_tag);
    pay_in.valid = in_valid;
  end

  // i[1] picks the a half, i[0] the b half: 0=ll 1=lh 2=hl 3=hh.
  // Only upper halves carry the operand's sign.
  for (genvar i = 0; i < 4; i++) begin : g_pp
    localparam int AH = i / 2;
    localparam int BH = i % 2;
    cpu_mul_pp #(.HALF_W(HALF_W)) u_pp (
      .a     (in_a[AH*HALF_W +: HALF_W]),
      .b     (in_b[BH*HALF_W +: HALF_W]),
      .signa (sa & (AH == 1)),
      .signb (sb & (BH == 1)),
      .p     (pp_d[i])
    );
  end

  // Sign-extended sum is exact; upper two bits are discarded.
  assign sum_full = (SUM_W'(pp_q[3]) << DATA_W)
                  + ((SUM_W'(pp_q[1]) + SUM_W'(pp_q[2])) << HALF_W)
                  + SUM_W'(pp_q[0]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 1; s <= STAGES; s++) pay_q[s] <= '0;
      for (int s = 2; s <= STAGES; s++) prod_q[s] <= '0;
      for (int i = 0; i < 4; i++) pp_q[i] <= '0;
    end else begin
      if (advance) begin
        pay_q[1]  <= pay_in;
        pp_q      <= pp_d;
        pay_q[2]  <= pay_q[1];
        prod_q[2] <= sum_full[PROD_W-1:0];
`ifdef CPU_MUL_OUT_REG_EN
        pay_q[3]  <= pay_q[2];
        prod_q[3] <= prod_q[2];
`endif
      end
      // Flush kills valids regardless of backpressure; data may go stale.
      if (flush)
        for (int s = 1; s <= STAGES; s++) pay_q[s].valid <= 1'b0;
    end
  end

  assign out_valid  = pay_q[STAGES].valid;
  assign out_tag    = pay_q[STAGES].tag[TAG_W-1:0];
  assign out_prod   = prod_q[STAGES];
  assign out_result = op_is_high(pay_q[STAGES].op) ? prod_q[STAGES][PROD_W-1:DATA_W]
                                                   : prod_q[STAGES][DATA_W-1:0];

endmodule
